// File: rtl/div_reservation_station.sv
// rtl/div_reservation_station.sv - age-ordered reservation station for the integer divide stage
// Optional zero-cycle CDB-to-issue forwarding: DIV_RS_CDB_FORWARD_EN
module div_reservation_station #(
    parameter int ROBsize    = 32,
    parameter int ROBsizeLog = $clog2(ROBsize + 1),
    parameter int RSsize     = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          flush_i,
    input  logic                          dispatch_valid_i,
    input  logic [9:0]                    dispatch_commands_i,
    input  logic [ROBsizeLog-1:0]         dispatch_tag_i,
    input  logic [63:0]                   dispatch_val1_i,
    input  logic [63:0]                   dispatch_val2_i,
    input  logic                          dispatch_rdy1_i,
    input  logic                          dispatch_rdy2_i,
    input  logic [ROBsizeLog-1:0]         dispatch_src1_tag_i,
    input  logic [ROBsizeLog-1:0]         dispatch_src2_tag_i,
    output logic                          full_o,
    input  logic                          cdb_valid_i,
    input  logic [ROBsizeLog-1:0]         cdb_tag_i,
    input  logic [63:0]                   cdb_val_i,
    output logic [63:0]                   reservationStationVal1_o,
    output logic [63:0]                   reservationStationVal2_o,
    output logic [9:0]                    reservationStationCommands_o,
    output logic [ROBsizeLog-1:0]         reservationStationTag_o,
    output logic                          readyRS_o,
    input  logic                          stallRS_i,
    output logic [$clog2(RSsize+1)-1:0]   count_o
);
    localparam int CW = $clog2(RSsize + 1);
    localparam int IW = $clog2(RSsize);

    typedef struct packed {
        logic [9:0]            cmd;
        logic [ROBsizeLog-1:0] tag;
        logic [63:0]           val1;
        logic                  rdy1;
        logic [ROBsizeLog-1:0] src1;
        logic [63:0]           val2;
        logic                  rdy2;
        logic [ROBsizeLog-1:0] src2;
    } entry_t;

    entry_t            ent_q   [RSsize];
    entry_t            woke    [RSsize];
    entry_t            nxt_ent [RSsize];
    entry_t            new_ent;
    logic [RSsize-1:0] valid_q;
    logic [RSsize-1:0] nxt_v;
    logic [RSsize-1:0] cand;
    logic [CW-1:0]     count_q;
    logic [IW-1:0]     sel_idx;
    logic [IW-1:0]     wr_idx;
    logic              found;
    logic              issue;
    logic              accept;

    // Entries as they look after this cycle's CDB broadcast is applied
    always_comb begin
        for (int i = 0; i < RSsize; i++) begin
            woke[i] = ent_q[i];
            if (!ent_q[i].rdy1 && cdb_valid_i && cdb_tag_i == ent_q[i].src1) begin
                woke[i].rdy1 = 1'b1;
                woke[i].val1 = cdb_val_i;
            end
            if (!ent_q[i].rdy2 && cdb_valid_i && cdb_tag_i == ent_q[i].src2) begin
                woke[i].rdy2 = 1'b1;
                woke[i].val2 = cdb_val_i;
            end
`ifdef DIV_RS_CDB_FORWARD_EN
            cand[i] = valid_q[i] & woke[i].rdy1 & woke[i].rdy2;
`else
            cand[i] = valid_q[i] & ent_q[i].rdy1 & ent_q[i].rdy2;
`endif
        end
    end

    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < RSsize; i++) begin
            if (cand[i] && !found) begin
                found   = 1'b1;
                sel_idx = IW'(i);
            end
        end
    end

    // Woken values equal stored values once rdy is set, so woke[] serves both modes
    always_comb begin
        readyRS_o                    = found;
        reservationStationVal1_o     = found ? woke[sel_idx].val1 : '0;
        reservationStationVal2_o     = found ? woke[sel_idx].val2 : '0;
        reservationStationCommands_o = found ? woke[sel_idx].cmd  : '0;
        reservationStationTag_o      = found ? woke[sel_idx].tag  : '0;
    end

    assign full_o  = (count_q == CW'(RSsize));
    assign count_o = count_q;
    assign issue   = found & ~stallRS_i;
    assign accept  = dispatch_valid_i & ~full_o;
    assign wr_idx  = IW'(count_q - CW'(issue));

    always_comb begin
        new_ent.cmd  = dispatch_commands_i;
        new_ent.tag  = dispatch_tag_i;
        new_ent.src1 = dispatch_src1_tag_i;
        new_ent.src2 = dispatch_src2_tag_i;
        new_ent.rdy1 = dispatch_rdy1_i;
        new_ent.val1 = dispatch_val1_i;
        new_ent.rdy2 = dispatch_rdy2_i;
        new_ent.val2 = dispatch_val2_i;
        if (!dispatch_rdy1_i && cdb_valid_i && cdb_tag_i == dispatch_src1_tag_i) begin
            new_ent.rdy1 = 1'b1;
            new_ent.val1 = cdb_val_i;
        end
        if (!dispatch_rdy2_i && cdb_valid_i && cdb_tag_i == dispatch_src2_tag_i) begin
            new_ent.rdy2 = 1'b1;
            new_ent.val2 = cdb_val_i;
        end
    end

    // Compact over the issued slot, then append the dispatch at the new tail
    always_comb begin
        for (int j = 0; j < RSsize; j++) begin
            nxt_ent[j] = woke[j];
            nxt_v[j]   = valid_q[j];
        end
        if (issue) begin
            for (int j = 0; j < RSsize - 1; j++) begin
                if (j >= int'(sel_idx)) begin
                    nxt_ent[j] = woke[j+1];
                    nxt_v[j]   = valid_q[j+1];
                end
            end
            nxt_v[RSsize-1] = 1'b0;
        end
        if (accept) begin
            nxt_ent[wr_idx] = new_ent;
            nxt_v[wr_idx]   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            valid_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= nxt_v;
            count_q <= count_q + CW'(accept) - CW'(issue);
        end
    end

    always_ff @(posedge clk_i) begin
        ent_q <= nxt_ent;
    end
endmodule

// File: tb/tb_div_reservation_station.sv
// tb/tb_div_reservation_station.sv - directed and random checks against a queue model
module tb_div_reservation_station;
    localparam int RS = 4;
    localparam int TW = 6;
`ifdef DIV_RS_CDB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_i, flush_i, dispatch_valid_i, dispatch_rdy1_i, dispatch_rdy2_i;
    logic [9:0] dispatch_commands_i;
    logic [TW-1:0] dispatch_tag_i, dispatch_src1_tag_i, dispatch_src2_tag_i, cdb_tag_i;
    logic [63:0] dispatch_val1_i, dispatch_val2_i, cdb_val_i;
    logic cdb_valid_i, stallRS_i;
    logic full_o, readyRS_o;
    logic [63:0] reservationStationVal1_o, reservationStationVal2_o;
    logic [9:0] reservationStationCommands_o;
    logic [TW-1:0] reservationStationTag_o;
    logic [2:0] count_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0]    cmd;
        logic [TW-1:0] tag;
        logic [63:0]   v1, v2;
        bit            r1, r2;
        logic [TW-1:0] s1, s2;
    } ment_t;
    ment_t q[$];

    div_reservation_station dut (
        .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
        .dispatch_valid_i(dispatch_valid_i), .dispatch_commands_i(dispatch_commands_i),
        .dispatch_tag_i(dispatch_tag_i), .dispatch_val1_i(dispatch_val1_i),
        .dispatch_val2_i(dispatch_val2_i), .dispatch_rdy1_i(dispatch_rdy1_i),
        .dispatch_rdy2_i(dispatch_rdy2_i), .dispatch_src1_tag_i(dispatch_src1_tag_i),
        .dispatch_src2_tag_i(dispatch_src2_tag_i), .full_o(full_o),
        .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_val_i(cdb_val_i),
        .reservationStationVal1_o(reservationStationVal1_o),
        .reservationStationVal2_o(reservationStationVal2_o),
        .reservationStationCommands_o(reservationStationCommands_o),
        .reservationStationTag_o(reservationStationTag_o),
        .readyRS_o(readyRS_o), .stallRS_i(stallRS_i), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Oldest entry whose operands are (or, with forwarding, become this cycle) available
    task automatic model_sel(output bit r, output int s, output logic [63:0] a, output logic [63:0] b,
                             output logic [9:0] c, output logic [TW-1:0] t);
        bit e1, e2;
        r = 0; s = 0; a = '0; b = '0; c = '0; t = '0;
        for (int i = 0; i < q.size(); i++) begin
            e1 = q[i].r1 || (FWD && cdb_valid_i && cdb_tag_i == q[i].s1);
            e2 = q[i].r2 || (FWD && cdb_valid_i && cdb_tag_i == q[i].s2);
            if (!r && e1 && e2) begin
                r = 1; s = i;
                a = q[i].r1 ? q[i].v1 : cdb_val_i;
                b = q[i].r2 ? q[i].v2 : cdb_val_i;
                c = q[i].cmd; t = q[i].tag;
            end
        end
    endtask

    task automatic compare_model();
        bit r; int s; logic [63:0] a, b; logic [9:0] c; logic [TW-1:0] t;
        model_sel(r, s, a, b, c, t);
        chk("m_ready", readyRS_o, r);
        chk("m_val1", reservationStationVal1_o, a);
        chk("m_val2", reservationStationVal2_o, b);
        chk("m_cmd", reservationStationCommands_o, c);
        chk("m_tag", reservationStationTag_o, t);
        chk("m_count", count_o, q.size());
        chk("m_full", full_o, q.size() == RS);
    endtask

    task automatic model_update();
        bit r, acc; int s; logic [63:0] a, b; logic [9:0] c; logic [TW-1:0] t; ment_t n;
        if (!reset_i || flush_i) begin
            q.delete();
            return;
        end
        model_sel(r, s, a, b, c, t);
        acc = dispatch_valid_i && (q.size() < RS);
        foreach (q[i]) begin
            if (!q[i].r1 && cdb_valid_i && cdb_tag_i == q[i].s1) begin q[i].r1 = 1; q[i].v1 = cdb_val_i; end
            if (!q[i].r2 && cdb_valid_i && cdb_tag_i == q[i].s2) begin q[i].r2 = 1; q[i].v2 = cdb_val_i; end
        end
        if (r && !stallRS_i) q.delete(s);
        if (acc) begin
            n.cmd = dispatch_commands_i; n.tag = dispatch_tag_i;
            n.s1 = dispatch_src1_tag_i; n.s2 = dispatch_src2_tag_i;
            n.r1 = dispatch_rdy1_i || (cdb_valid_i && cdb_tag_i == dispatch_src1_tag_i);
            n.r2 = dispatch_rdy2_i || (cdb_valid_i && cdb_tag_i == dispatch_src2_tag_i);
            n.v1 = (!dispatch_rdy1_i && n.r1) ? cdb_val_i : dispatch_val1_i;
            n.v2 = (!dispatch_rdy2_i && n.r2) ? cdb_val_i : dispatch_val2_i;
            q.push_back(n);
        end
    endtask

    task automatic cycle();
        #1 compare_model();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        reset_i = 1; flush_i = 0; dispatch_valid_i = 0; cdb_valid_i = 0;
        cdb_tag_i = '0; cdb_val_i = '0;
    endtask

    task automatic disp(input logic [TW-1:0] tag, input logic [63:0] v1, input bit r1, input logic [TW-1:0] s1,
                        input logic [63:0] v2, input bit r2, input logic [TW-1:0] s2);
        dispatch_valid_i = 1; dispatch_commands_i = {4'b1010, tag}; dispatch_tag_i = tag;
        dispatch_val1_i = v1; dispatch_rdy1_i = r1; dispatch_src1_tag_i = s1;
        dispatch_val2_i = v2; dispatch_rdy2_i = r2; dispatch_src2_tag_i = s2;
    endtask

    task automatic cdb(input logic [TW-1:0] t, input logic [63:0] v);
        cdb_valid_i = 1; cdb_tag_i = t; cdb_val_i = v;
    endtask

    initial begin
        idle();
        reset_i = 0; stallRS_i = 0;
        disp(0, 0, 0, 0, 0, 0, 0);
        dispatch_valid_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        q.delete();

        idle();
        #1;
        chk("rst_count", count_o, 0);
        chk("rst_ready", readyRS_o, 0);
        chk("rst_full", full_o, 0);
        disp(5, 15, 1, 0, 3, 1, 0);
        cycle();
        idle(); #1;
        chk("lat_ready", readyRS_o, 1);
        chk("lat_val1", reservationStationVal1_o, 15);
        chk("lat_val2", reservationStationVal2_o, 3);
        chk("lat_tag", reservationStationTag_o, 5);
        chk("lat_count", count_o, 1);
        cycle();
        #1 chk("lat_drain", count_o, 0);

        disp(4, 100, 1, 0, 0, 0, 9);
        cycle();
        idle(); cdb(9, 7); #1;
`ifdef DIV_RS_CDB_FORWARD_EN
        chk("wk_fwd_ready", readyRS_o, 1);
        chk("wk_fwd_val2", reservationStationVal2_o, 7);
        cycle();
`else
        chk("wk_bcast_ready", readyRS_o, 0);
        cycle();
        idle(); #1;
        chk("wk_ready", readyRS_o, 1);
        chk("wk_val1", reservationStationVal1_o, 100);
        chk("wk_val2", reservationStationVal2_o, 7);
        cycle();
`endif
        idle(); #1 chk("wk_count", count_o, 0);

        stallRS_i = 1;
        disp(1, 50, 1, 0, 0, 0, 20); cycle();
        disp(2, 6, 1, 0, 2, 1, 0);   cycle();
        disp(3, 8, 1, 0, 4, 1, 0);   cycle();
        idle(); #1;
        chk("age_b_ready", readyRS_o, 1);
        chk("age_b_tag", reservationStationTag_o, 2);
        cycle();
        #1 chk("age_b_hold", reservationStationTag_o, 2);
        stallRS_i = 0;
        cycle();
        #1 chk("age_c_tag", reservationStationTag_o, 3);
        cycle();
        #1 chk("age_a_wait", readyRS_o, 0);
        cdb(20, 5);
`ifdef DIV_RS_CDB_FORWARD_EN
        #1 chk("age_a_fwd_tag", reservationStationTag_o, 1);
        cycle();
`else
        #1 chk("age_a_bcast", readyRS_o, 0);
        cycle();
        idle(); #1;
        chk("age_a_tag", reservationStationTag_o, 1);
        chk("age_a_val2", reservationStationVal2_o, 5);
        cycle();
`endif
        idle(); #1 chk("age_empty", count_o, 0);

        stallRS_i = 1;
        for (int i = 0; i < 4; i++) begin
            disp(TW'(10 + i), 64'(i + 1), 1, 0, 1, 1, 0);
            cycle();
        end
        idle(); #1;
        chk("full_flag", full_o, 1);
        chk("full_count", count_o, 4);
        disp(14, 9, 1, 0, 9, 1, 0);
        cycle();
        #1 chk("full_drop", count_o, 4);
        stallRS_i = 0;
        cycle();
        idle(); #1;
        chk("full_issue_count", count_o, 3);
        chk("full_t11", reservationStationTag_o, 11);
        cycle();
        #1 chk("full_t12", reservationStationTag_o, 12);
        cycle();
        #1 chk("full_t13", reservationStationTag_o, 13);
        cycle();
        #1 chk("full_lost", count_o, 0);

        disp(15, 0, 0, 12, 9, 1, 0);
        cdb(12, 64'hDEAD);
        cycle();
        idle(); #1;
        chk("col_ready", readyRS_o, 1);
        chk("col_val1", reservationStationVal1_o, 64'hDEAD);
        cycle();

        for (int k = 0; k < 2; k++) begin
            stallRS_i = 1;
            for (int i = 0; i < 3; i++) begin
                disp(TW'(21 + i), 1, 1, 0, 1, 1, 0);
                cycle();
            end
            disp(24, 1, 1, 0, 1, 1, 0);
            if (k == 0) flush_i = 1; else reset_i = 0;
            cycle();
            idle(); #1;
            chk(k == 0 ? "flush_count" : "reset_count", count_o, 0);
            chk(k == 0 ? "flush_ready" : "reset_ready", readyRS_o, 0);
            cycle();
        end
        stallRS_i = 0;

        for (int n = 0; n < 1500; n++) begin
            idle();
            if ($urandom_range(0, 1) == 1) begin
                disp(TW'($urandom_range(0, 31)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                     TW'($urandom_range(0, 7)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                     TW'($urandom_range(0, 7)));
                dispatch_commands_i = 10'($urandom);
            end
            if ($urandom_range(0, 2) != 0) cdb(TW'($urandom_range(0, 7)), {$urandom, $urandom});
            stallRS_i = ($urandom_range(0, 9) < 3);
            flush_i = ($urandom_range(0, 99) < 2);
            reset_i = !($urandom_range(0, 99) < 1);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_reservation_station.md
Name: div_reservation_station

Overview:
- Reservation station feeding the integer divide execute stage.
- Accepts dispatched divide ops from rename/dispatch and holds up to RSsize entries.
- Snoops the common data bus (CDB) to wake pending operands.
- Issues the oldest fully-ready entry to the divide stage through its readyRS/stallRS handshake.

Parameters:
ROBsize, 32, number of ROB entries; sets the tag space
ROBsizeLog, $clog2(ROBsize+1), tag width in bits
RSsize, 4, number of station entries (2..8)

Ports:
clk_i  in  1  clock; all state updates on the rising edge
reset_i  in  1  synchronous reset, active-low
flush_i  in  1  squash all entries (mispredict recovery)
dispatch_valid_i  in  1  dispatch request this cycle
dispatch_commands_i  in  10  op command bits
dispatch_tag_i  in  ROBsizeLog  destination ROB tag
dispatch_val1_i / dispatch_val2_i  in  64 each  operand values; valid when the matching rdy bit is 1
dispatch_rdy1_i / dispatch_rdy2_i  in  1 each  operand already available
dispatch_src1_tag_i / dispatch_src2_tag_i  in  ROBsizeLog each  producer tag when the operand is not ready
full_o  out  1  no free entry; dispatch is ignored
cdb_valid_i  in  1  CDB broadcast valid
cdb_tag_i  in  ROBsizeLog  broadcast tag
cdb_val_i  in  64  broadcast value
reservationStationVal1_o  out  64  dividend to divide stage
reservationStationVal2_o  out  64  divisor to divide stage
reservationStationCommands_o  out  10  commands of issuing entry
reservationStationTag_o  out  ROBsizeLog  destination tag of issuing entry
readyRS_o  out  1  an issuable entry is presented
stallRS_i  in  1  divide stage not accepting (active-high)
count_o  out  $clog2(RSsize+1)  occupied entries

Behaviour:
- Storage: compacted queue. Entry 0 is the oldest. Per entry: valid, commands, dest tag, val1/rdy1/src1tag, val2/rdy2/src2tag.
- Reset (reset_i==0 at a clock edge): all valid bits 0, count_o=0, full_o=0, readyRS_o=0. Data outputs are 0 because no entry is selected.
- full_o = (count==RSsize). It is combinational from count only, so an issue in the same cycle does not free a slot for dispatch.
- Dispatch: when dispatch_valid_i & ~full_o, the new entry is written at position count (after any compaction for an issue in the same cycle). Dispatch while full is dropped silently.
- Dispatch/CDB bypass: if an operand is not ready and cdb_valid_i with cdb_tag_i == its src tag in the same cycle, the entry is stored with rdy=1 and val=cdb_val_i.
- Wakeup: every valid entry compares both pending src tags against the CDB each cycle. On a match it latches cdb_val_i and sets rdy. Both operands may wake from one broadcast.
- Select: readyRS_o=1 iff some valid entry has rdy1&rdy2. The lowest index (oldest) such entry drives the reservationStation* outputs. With readyRS_o=0, data outputs are 0.
- Issue: handshake completes when readyRS_o & ~stallRS_i. The selected entry is removed and younger entries shift down one slot at that edge, keeping their CDB wakeups from that cycle.
- Latency: with both operands ready at dispatch and no stall, readyRS_o rises the cycle after dispatch. A CDB wake makes the entry issuable the next cycle (without the optional feature).
- count_o next = count + accepted dispatch − issue. Simultaneous dispatch and issue leaves the count unchanged.
- flush_i: all entries invalid next cycle; it overrides dispatch and issue in the same cycle. reset_i has priority over flush_i.
- The CDB tag never matches a ready operand. Stale src tags of ready operands are ignored.

Optional Feature:
DIV_RS_CDB_FORWARD_EN
- Defined: an entry whose only missing operand(s) match the current CDB broadcast counts as ready this cycle and may be selected. Forwarded operands are muxed from cdb_val_i onto the outputs, giving zero-cycle wakeup-to-issue. Age priority is unchanged.
- Undefined: wakeup is registered only; issue is earliest on the cycle after the broadcast.

Test Plan:
- Reset/idle: hold reset_i=0 for 2 cycles, release -> count_o=0, readyRS_o=0, full_o=0. Dispatch with rdy both=1, val1=15, val2=3, tag=5, stallRS_i=0 -> next cycle readyRS_o=1, Val1=15, Val2=3, Tag=5; count_o returns to 0 one edge later.
- Wakeup: dispatch val1 ready=100, op2 pending on src2 tag 9, then CDB tag=9 val=7 -> readyRS_o=0 during the broadcast cycle, =1 the next cycle with Val2=7. With the macro defined, readyRS_o=1 in the broadcast cycle itself with Val2=7.
- Age/stall: dispatch A (tag 1, pending tag 20), then B and C (tags 2 and 3, ready), stallRS_i=1 -> B presented and held steady. Release stall -> issue order B, C. Broadcast tag 20 -> A issues last.
- Full: dispatch 4 ready ops with stallRS_i=1 -> full_o=1, count_o=4. A 5th dispatch is ignored. Release stall for 1 cycle while dispatching -> count_o=3 and the 5th dispatch is lost.
- Dispatch/CDB collision: dispatch with src1 tag 12 pending while CDB broadcasts tag 12, val 0xDEAD -> entry issues with Val1=0xDEAD.
- Flush/reset mid-op: 3 entries held, flush_i=1 together with a dispatch -> count_o=0 and readyRS_o=0 next cycle. Repeat with reset_i=0 instead -> same result.
